// File: rtl/alu_seq_ctrl_if.sv
// Request, nibble-ALU and response signals between the decoder, the sequencer and the nibble ALU.
// The slave side is the sequencer; the master side is the decoder plus the nibble ALU.
interface alu_seq_ctrl_if #(
    parameter int NIB_W = 4
);
    logic                 req_valid;
    logic                 req_ready;
    logic [2:0]           req_op;
    logic                 req_wide;
    logic [4*NIB_W-1:0]   req_a;
    logic [4*NIB_W-1:0]   req_b;
    logic [3:0]           req_flags;

    logic [NIB_W-1:0]     alu_a;
    logic [NIB_W-1:0]     alu_b;
    logic [2:0]           alu_op;
    logic                 alu_c_in;
    logic [NIB_W-1:0]     alu_out;
    logic                 alu_c_out;

    logic                 resp_valid;
    logic [4*NIB_W-1:0]   resp_result;
    logic [3:0]           resp_flags;
    logic                 resp_we;

    modport slave (
        input  req_valid, req_op, req_wide, req_a, req_b, req_flags,
        input  alu_out, alu_c_out,
        output req_ready,
        output alu_a, alu_b, alu_op, alu_c_in,
        output resp_valid, resp_result, resp_flags, resp_we
    );

    modport master (
        output req_valid, req_op, req_wide, req_a, req_b, req_flags,
        output alu_out, alu_c_out,
        input  req_ready,
        input  alu_a, alu_b, alu_op, alu_c_in,
        input  resp_valid, resp_result, resp_flags, resp_we
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Sequences the nibble ALU through 2 (8-bit) or 4 (16-bit add) nibble steps and builds Z/N/H/C flags.
// Response pulses 3 / 5 cycles after accept; one request in flight, req_ready only while idle.
module alu_seq_ctrl #(
    parameter int NIB_W = 4
) (
    input  logic           clock,
    input  logic           reset_n,
    alu_seq_ctrl_if.slave  bus
);
    localparam int W = 4 * NIB_W;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_ADC = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_SBC = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_CP  = 3'd7;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        N0   = 3'd1,
        N1   = 3'd2,
        N2   = 3'd3,
        N3   = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t            state;
    logic [2:0]        op_q;
    logic              wide_q;
    logic [W-1:0]      a_q;
    logic [W-1:0]      b_q;
    logic [W-1:0]      res_q;
    logic              z_q;
    logic              c_q;
    logic              chain_c;
    logic              h_q;

    logic [1:0]        nib_idx;
    logic [NIB_W-1:0]  a_nib;
    logic [NIB_W-1:0]  b_nib;
    logic [2*NIB_W-1:0] byte_res;
    logic [W-1:0]      wide_res;
    logic              is_sub;
    logic              is_arith;

    assign bus.req_ready = (state == IDLE);

    assign is_sub   = (op_q == OP_SUB) || (op_q == OP_SBC) || (op_q == OP_CP);
    assign is_arith = !op_q[2] || (op_q == OP_CP);

    // Final nibble is still on alu_out at the last step's edge, so splice it in directly.
    assign byte_res = {bus.alu_out, res_q[NIB_W-1:0]};
    assign wide_res = {bus.alu_out, res_q[3*NIB_W-1:0]};

    always_comb begin
        nib_idx = 2'd0;
        case (state)
            N1:      nib_idx = 2'd1;
            N2:      nib_idx = 2'd2;
            N3:      nib_idx = 2'd3;
            default: nib_idx = 2'd0;
        endcase
    end

    assign a_nib = a_q[nib_idx*NIB_W +: NIB_W];
    assign b_nib = b_q[nib_idx*NIB_W +: NIB_W];

    always_comb begin
        bus.alu_a    = '0;
        bus.alu_b    = '0;
        bus.alu_op   = OP_ADD;
        bus.alu_c_in = 1'b0;
        case (state)
            N0: begin
                bus.alu_a    = a_nib;
                bus.alu_b    = b_nib;
                bus.alu_op   = wide_q ? OP_ADD : op_q;
                bus.alu_c_in = !wide_q && ((op_q == OP_ADC) || (op_q == OP_SBC)) && c_q;
            end
            N1, N2, N3: begin
                bus.alu_a    = a_nib;
                bus.alu_b    = b_nib;
                // Upper nibbles always chain: add/sub become their carry-in forms.
                if (wide_q || op_q == OP_ADD)
                    bus.alu_op = OP_ADC;
                else if (op_q == OP_SUB)
                    bus.alu_op = OP_SBC;
                else
                    bus.alu_op = op_q;
                bus.alu_c_in = chain_c;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            op_q            <= '0;
            wide_q          <= 1'b0;
            a_q             <= '0;
            b_q             <= '0;
            res_q           <= '0;
            z_q             <= 1'b0;
            c_q             <= 1'b0;
            chain_c         <= 1'b0;
            h_q             <= 1'b0;
            bus.resp_valid  <= 1'b0;
            bus.resp_result <= '0;
            bus.resp_flags  <= '0;
            bus.resp_we     <= 1'b0;
        end else begin
            bus.resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        op_q   <= bus.req_op;
                        wide_q <= bus.req_wide;
                        a_q    <= bus.req_a;
                        b_q    <= bus.req_b;
                        z_q    <= bus.req_flags[3];
                        c_q    <= bus.req_flags[0];
                        state  <= N0;
                    end
                end
                N0: begin
                    res_q[NIB_W-1:0] <= bus.alu_out;
                    chain_c          <= bus.alu_c_out;
                    h_q              <= bus.alu_c_out;
                    state            <= N1;
                end
                N1: begin
                    res_q[2*NIB_W-1:NIB_W] <= bus.alu_out;
                    chain_c                <= bus.alu_c_out;
                    if (wide_q) begin
                        state <= N2;
                    end else begin
                        bus.resp_valid  <= 1'b1;
                        bus.resp_result <= {{(W-2*NIB_W){1'b0}}, byte_res};
                        bus.resp_flags  <= {(byte_res == '0), is_sub,
                                            is_arith ? h_q : (op_q == OP_AND),
                                            is_arith & bus.alu_c_out};
                        bus.resp_we     <= (op_q != OP_CP);
                        state           <= DONE;
                    end
                end
                N2: begin
                    res_q[3*NIB_W-1:2*NIB_W] <= bus.alu_out;
                    chain_c                  <= bus.alu_c_out;
                    h_q                      <= bus.alu_c_out;
                    state                    <= N3;
                end
                N3: begin
                    res_q[W-1:3*NIB_W] <= bus.alu_out;
                    chain_c            <= bus.alu_c_out;
                    bus.resp_valid     <= 1'b1;
                    bus.resp_result    <= wide_res;
                    bus.resp_flags     <= {z_q, 1'b0, h_q, bus.alu_c_out};
                    bus.resp_we        <= 1'b1;
                    state              <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: behavioural nibble ALU, byte/word-level reference model and directed vectors.
module tb_alu_seq_ctrl;
    logic clock   = 1'b0;
    logic reset_n = 1'b1;

    always #5 clock = ~clock;

    alu_seq_ctrl_if #(.NIB_W(4)) bus ();

    alu_seq_ctrl #(.NIB_W(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Nibble ALU: 5-bit arithmetic, bit 4 is carry (add) or borrow (sub/sbc/cp).
    logic [4:0] nib_s;
    always_comb begin
        nib_s = '0;
        case (bus.alu_op)
            3'd0:       nib_s = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            3'd1:       nib_s = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {4'b0, bus.alu_c_in};
            3'd2:       nib_s = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
            3'd3, 3'd7: nib_s = {1'b0, bus.alu_a} - {1'b0, bus.alu_b} - {4'b0, bus.alu_c_in};
            3'd4:       nib_s = {1'b0, bus.alu_a & bus.alu_b};
            3'd5:       nib_s = {1'b0, bus.alu_a ^ bus.alu_b};
            default:    nib_s = {1'b0, bus.alu_a | bus.alu_b};
        endcase
    end
    assign bus.alu_out   = nib_s[3:0];
    assign bus.alu_c_out = nib_s[4];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int          due;
        logic [15:0] res;
        logic [3:0]  fl;
        logic        we;
    } exp_t;

    exp_t q[$];

    function automatic exp_t model(input logic [2:0] op, input logic w,
                                   input logic [15:0] a, input logic [15:0] b,
                                   input logic [3:0] f);
        exp_t e;
        int   ai, bi, ci, r;
        logic z, n, h, c;
        e.due = 0;
        if (w) begin
            ai = int'(a);
            bi = int'(b);
            r  = ai + bi;
            h  = ((ai % 4096) + (bi % 4096)) > 4095;
            c  = r > 65535;
            e.res = r[15:0];
            e.fl  = {f[3], 1'b0, h, c};
            e.we  = 1'b1;
        end else begin
            ai = int'(a[7:0]);
            bi = int'(b[7:0]);
            ci = (op == 3'd1 || op == 3'd3) ? int'(f[0]) : 0;
            n = 1'b0; h = 1'b0; c = 1'b0; r = 0;
            case (op)
                3'd0, 3'd1: begin
                    r = ai + bi + ci;
                    h = ((ai % 16) + (bi % 16) + ci) > 15;
                    c = r > 255;
                end
                3'd2, 3'd3, 3'd7: begin
                    r = ai - bi - ci;
                    n = 1'b1;
                    h = (ai % 16) < ((bi % 16) + ci);
                    c = ai < (bi + ci);
                end
                3'd4: begin r = ai & bi; h = 1'b1; end
                3'd5: r = ai ^ bi;
                default: r = ai | bi;
            endcase
            z = (r[7:0] == 8'h00);
            e.res = {8'h00, r[7:0]};
            e.fl  = {z, n, h, c};
            e.we  = (op != 3'd7);
        end
        return e;
    endfunction

    // Cycle-by-cycle compare of handshake and response against the model.
    always @(negedge clock) begin : cmp
        logic mready, mvld;
        exp_t e;
        cyc++;
        if (!reset_n) begin
            q.delete();
            chk("rst_resp_valid", bus.resp_valid, 1'b0);
        end else begin
            mready = (q.size() == 0);
            mvld   = !mready && (q[0].due == cyc);
            chk("req_ready", bus.req_ready, mready);
            chk("resp_valid", bus.resp_valid, mvld);
            if (mvld) begin
                chk("model_result", bus.resp_result, q[0].res);
                chk("model_flags", bus.resp_flags, q[0].fl);
                chk("model_we", bus.resp_we, q[0].we);
                void'(q.pop_front());
            end
            if (bus.req_valid && mready) begin
                e = model(bus.req_op, bus.req_wide, bus.req_a, bus.req_b, bus.req_flags);
                e.due = cyc + (bus.req_wide ? 5 : 3);
                q.push_back(e);
            end
        end
    end

    task automatic start(input logic [2:0] op, input logic w, input logic [15:0] a,
                         input logic [15:0] b, input logic [3:0] f);
        @(posedge clock); #1;
        bus.req_op = op; bus.req_wide = w; bus.req_a = a; bus.req_b = b; bus.req_flags = f;
        bus.req_valid = 1'b1;
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        bus.req_a     = 16'($urandom);
        bus.req_b     = 16'($urandom);
        bus.req_op    = 3'($urandom);
        bus.req_flags = 4'($urandom);
        bus.req_wide  = 1'($urandom);
    endtask

    task automatic wait_resp(input string nm, input int lat, input logic [15:0] r,
                             input logic [3:0] f, input logic we);
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        while (!got && n < 12) begin
            @(negedge clock);
            n++;
            if (bus.resp_valid) got = 1'b1;
        end
        chk({nm, "_seen"}, 32'(got), 32'd1);
        if (got) begin
            chk({nm, "_latency"}, n, lat);
            chk({nm, "_result"}, bus.resp_result, r);
            chk({nm, "_flags"}, bus.resp_flags, f);
            chk({nm, "_we"}, bus.resp_we, we);
        end
    endtask

    int acc[$];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_wide = 1'b0;
        bus.req_a = '0; bus.req_b = '0; bus.req_flags = '0;
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_result", bus.resp_result, 16'h0000);
        chk("rst_flags", bus.resp_flags, 4'h0);
        chk("rst_we", bus.resp_we, 1'b0);
        @(posedge clock); #1 reset_n = 1'b1;
        @(negedge clock);
        chk("idle_ready", bus.req_ready, 1'b1);
        chk("idle_alu", {bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_c_in}, 12'h000);

        // Upper operand byte must be ignored for 8-bit ops.
        start(3'd0, 1'b0, 16'hFF3A, 16'hABC6, 4'b0000);
        wait_resp("add", 3, 16'h0000, 4'b1011, 1'b1);

        start(3'd3, 1'b0, 16'h0010, 16'h0001, 4'b0001);
        chk("sbc_n0_op", bus.alu_op, 3'd3);
        chk("sbc_n0_cin", bus.alu_c_in, 1'b1);
        chk("sbc_n0_ab", {bus.alu_a, bus.alu_b}, 8'h01);
        @(posedge clock); #1;
        chk("sbc_n1_op", bus.alu_op, 3'd3);
        chk("sbc_n1_ab", {bus.alu_a, bus.alu_b}, 8'h10);
        wait_resp("sbc", 2, 16'h000E, 4'b0110, 1'b1);

        start(3'd7, 1'b0, 16'h0042, 16'h0042, 4'b0000);
        wait_resp("cp_eq", 3, 16'h0000, 4'b1100, 1'b0);
        start(3'd7, 1'b0, 16'h0042, 16'h0050, 4'b0000);
        wait_resp("cp_lt", 3, 16'h00F2, 4'b0101, 1'b0);

        start(3'd4, 1'b0, 16'h00F0, 16'h000F, 4'b0000);
        wait_resp("and", 3, 16'h0000, 4'b1010, 1'b1);
        start(3'd6, 1'b0, 16'h0000, 16'h0000, 4'b0001);
        wait_resp("or", 3, 16'h0000, 4'b1000, 1'b1);
        start(3'd5, 1'b0, 16'h00FF, 16'h000F, 4'b1111);
        wait_resp("xor", 3, 16'h00F0, 4'b0000, 1'b1);
        @(negedge clock);
        chk("hold_result", bus.resp_result, 16'h00F0);
        chk("done_alu_idle", {bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_c_in}, 12'h000);

        start(3'd1, 1'b0, 16'h000F, 16'h0001, 4'b0001);
        wait_resp("adc", 3, 16'h0011, 4'b0010, 1'b1);
        start(3'd2, 1'b0, 16'h0000, 16'h0001, 4'b0000);
        wait_resp("sub", 3, 16'h00FF, 4'b0111, 1'b1);

        start(3'd5, 1'b1, 16'h0FFF, 16'h0001, 4'b1000);
        wait_resp("wide_h", 5, 16'h1000, 4'b1010, 1'b1);
        start(3'd0, 1'b1, 16'hFFFF, 16'h0001, 4'b0000);
        wait_resp("wide_c", 5, 16'h0000, 4'b0011, 1'b1);

        // Held request: accepts must land every 4 cycles.
        @(posedge clock); #1;
        bus.req_op = 3'd0; bus.req_wide = 1'b0; bus.req_a = 16'h0001; bus.req_b = 16'h0002;
        bus.req_flags = 4'b0000; bus.req_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            @(negedge clock);
            if (bus.req_valid && bus.req_ready) acc.push_back(cyc);
        end
        @(posedge clock); #1 bus.req_valid = 1'b0;
        repeat (6) @(posedge clock);
        chk("b2b_count", 32'(acc.size() >= 4), 32'd1);
        for (int i = 1; i < acc.size(); i++) chk("b2b_spacing", acc[i] - acc[i-1], 4);

        // Reset in N1 discards the op.
        start(3'd0, 1'b0, 16'h003A, 16'h00C6, 4'b0000);
        @(posedge clock); #1 reset_n = 1'b0;
        @(posedge clock); #1 reset_n = 1'b1;
        @(negedge clock);
        chk("post_rst_ready", bus.req_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("post_rst_no_resp", bus.resp_valid, 1'b0);
            @(negedge clock);
        end
        start(3'd5, 1'b0, 16'h00FF, 16'h000F, 4'b0000);
        wait_resp("post_rst_xor", 3, 16'h00F0, 4'b0000, 1'b1);

        repeat (3) @(posedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Controller that sequences the 4-bit nibble ALU to execute complete 8-bit ALU ops and 16-bit adds (ADD HL,rr) for the CPU core.
- Accepts one request at a time from the instruction decoder over a valid/ready handshake and owns the nibble phase. No free-running phase toggle.
- Drives the nibble ALU's operand, op and carry-in ports, assembles the result and produces Game Boy Z/N/H/C flags.

Parameters:
- NIB_W, 4, nibble ALU datapath width (fixed; not intended to be changed)

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept (IDLE only)
- req_op  in  3  0 add, 1 adc, 2 sub, 3 sbc, 4 and, 5 xor, 6 or, 7 cp
- req_wide  in  1  1 = 16-bit add; req_op ignored
- req_a  in  16  operand A (bits 15:8 ignored when req_wide=0)
- req_b  in  16  operand B (bits 15:8 ignored when req_wide=0)
- req_flags  in  4  current F flags {Z,N,H,C}
- alu_a  out  4  nibble ALU operand A
- alu_b  out  4  nibble ALU operand B
- alu_op  out  3  nibble ALU opcode
- alu_c_in  out  1  nibble ALU carry/borrow in
- alu_out  in  4  nibble ALU result
- alu_c_out  in  1  nibble ALU carry (add) / borrow (sub, sbc, cp), 1 = carry/borrow
- resp_valid  out  1  one-cycle result pulse
- resp_result  out  16  result; upper byte 0 when not wide
- resp_flags  out  4  {Z,N,H,C}
- resp_we  out  1  destination write enable (0 for cp)

Behaviour:
- Reset (async, reset_n=0): state IDLE. req_ready=1 after release. resp_valid=0, resp_result=0, resp_flags=0, resp_we=0. Internal operand, result and carry registers cleared.
- States: IDLE, N0, N1, N2, N3, DONE.
- IDLE: req_ready=1. req_valid=1 at a rising edge latches op, wide, a, b and req_flags, then goes to N0. req_ready=0 in all other states; no back-to-back accept.
- Nk (k=0..3): alu_a/alu_b = latched a/b bits [4k+3:4k], combinationally from state.
  - The rising edge stores alu_out into result[4k+3:4k] and alu_c_out into the chain carry.
  - N0 stores the H source; N2 in wide mode stores the H source.
- Opcode mapping:
  - N0 uses the latched op; for wide, alu_op=add.
  - N1..N3: add→adc, sub→sbc, adc/sbc/logic/cp unchanged; wide uses adc.
- Carry-in:
  - N0: latched C for adc/sbc; 0 for add, sub, cp, logic and wide.
  - N1..N3: chain carry.
- Transitions: N0→N1. N1→DONE if not wide, else N2. N2→N3→DONE. DONE→IDLE unconditionally.
- DONE: resp_valid=1 for exactly one cycle. resp_result, resp_flags and resp_we are valid while resp_valid=1 and hold their values until the next DONE.
- Latency: accept edge at cycle T → resp_valid high during cycle T+3 (8-bit) or T+5 (wide). Throughput is one op per 4 (8-bit) or 6 (wide) cycles.
- Flags, 8-bit:
  - Z = (result[7:0]==0), computed from the assembled byte, including for cp.
  - N = 1 for sub/sbc/cp, else 0.
  - H = N0 carry/borrow for arith and cp; 1 for and; 0 for xor/or.
  - C = N1 carry/borrow for arith and cp; 0 for logic.
- Flags, wide: Z = latched Z (unchanged); N = 0; H = carry out of bit 11 (N2); C = carry out of bit 15 (N3).
- resp_we = 0 for cp (A not written); 1 otherwise.
- req_valid deasserted or operands changing after accept has no effect, since operands are latched.
- reset_n asserted mid-op: op is discarded, no resp_valid pulse, state returns to IDLE.
- alu_* outputs in IDLE/DONE: alu_a=alu_b=0, alu_op=0, alu_c_in=0.

Test Plan:
- add A=0x3A, B=0xC6, wide=0 → resp_valid at T+3, result=0x00, flags Z1 N0 H1 C1, we=1.
- sbc A=0x10, B=0x01, C_in=1 → result=0x0E, flags Z0 N1 H1 C0. Check N0 drives alu_op=sbc with alu_c_in=1; N1 drives sbc.
- cp A=0x42, B=0x42 → result=0x00, flags Z1 N1 H0 C0, we=0. Repeat with B=0x50: Z0 N1 H0 C1.
- and 0xF0,0x0F → 0x00, flags Z1 N0 H1 C0. or 0x00,0x00 → Z1 H0. xor 0xFF,0x0F → 0xF0, Z0.
- wide add A=0x0FFF, B=0x0001, req_flags Z=1 → resp_valid at T+5, result=0x1000, flags Z1 N0 H1 C0. A=0xFFFF, B=0x0001 → 0x0000, C1 H1, Z preserved.
- Hold req_valid high continuously → accepts spaced exactly 4 cycles (8-bit). Assert reset_n low during N1 → no resp_valid, req_ready=1 the cycle after release, next request completes correctly.
